// File: rtl/mult_writeback_unit.sv
// Sequential 8x8 shift-add multiplier that writes its 16-bit product back to the
// register file as two byte writes (low half, then high half).
module mult_writeback_unit (
    input  logic        clock,
    input  logic        resetN,
    input  logic        start,
    input  logic [7:0]  operandA,
    input  logic [7:0]  operandB,
    input  logic        signedMode,
    input  logic [2:0]  destLo,
    input  logic [2:0]  destHi,
    output logic        busy,
    output logic        done,
    output logic        regWrite,
    output logic [2:0]  writeRegister,
    output logic [7:0]  writeData,
    output logic [15:0] product
);

    localparam int unsigned DataW = 8;
    localparam int unsigned AddrW = 3;
    localparam int unsigned ProdW = 2 * DataW;
    localparam int unsigned StepW = 3;
    localparam logic [StepW-1:0] LastStep = StepW'(DataW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } state_t;

    state_t             state;
    logic [ProdW-1:0]   acc;
    logic [ProdW-1:0]   multiplicand;
    logic [DataW-1:0]   multiplier;
    logic [StepW-1:0]   stepCount;
    logic [AddrW-1:0]   destLoReg;
    logic [AddrW-1:0]   destHiReg;
    logic               signedReg;
    logic               signDiffReg;

    logic [DataW-1:0]   magA;
    logic [DataW-1:0]   magB;
    logic [ProdW-1:0]   accNext;
    logic [ProdW-1:0]   finalProduct;
    logic               acceptStart;

    // Operand magnitudes, next accumulator value and sign-corrected result.
    always_comb begin
        magA         = operandA;
        magB         = operandB;
        accNext      = acc;
        finalProduct = '0;
        if (signedMode && operandA[DataW-1]) begin
            magA = DataW'(8'd0 - operandA);
        end
        if (signedMode && operandB[DataW-1]) begin
            magB = DataW'(8'd0 - operandB);
        end
        if (multiplier[0]) begin
            accNext = ProdW'(acc + multiplicand);
        end
        finalProduct = (signedReg && signDiffReg) ? ProdW'(16'd0 - accNext) : accNext;
    end

    // A start seen on the final write edge chains straight into the next multiply.
    assign acceptStart = start && ((state == IDLE) || (state == WR_HI));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            product       <= '0;
            acc           <= '0;
            multiplicand  <= '0;
            multiplier    <= '0;
            stepCount     <= '0;
            destLoReg     <= '0;
            destHiReg     <= '0;
            signedReg     <= 1'b0;
            signDiffReg   <= 1'b0;
        end else begin
            done          <= 1'b0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                end
                MUL: begin
                    acc          <= accNext;
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    stepCount    <= stepCount + StepW'(1);
                    if (stepCount == LastStep) begin
                        state         <= WR_LO;
                        product       <= finalProduct;
                        regWrite      <= 1'b1;
                        writeRegister <= destLoReg;
                        writeData     <= finalProduct[DataW-1:0];
                    end
                end
                WR_LO: begin
                    state         <= WR_HI;
                    regWrite      <= 1'b1;
                    writeRegister <= destHiReg;
                    writeData     <= product[ProdW-1:DataW];
                end
                WR_HI: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Capture everything the operation needs so later input changes are harmless.
            if (acceptStart) begin
                state        <= MUL;
                busy         <= 1'b1;
                acc          <= '0;
                stepCount    <= '0;
                multiplicand <= ProdW'(magA);
                multiplier   <= magB;
                destLoReg    <= destLo;
                destHiReg    <= destHi;
                signedReg    <= signedMode;
                signDiffReg  <= operandA[DataW-1] ^ operandB[DataW-1];
            end
        end
    end

endmodule

// File: tb/tb_mult_writeback_unit.sv
// Directed bench for mult_writeback_unit: hand-computed products, write timing,
// back-to-back chaining and mid-operation reset.
module tb_mult_writeback_unit;

    logic        clock;
    logic        resetN;
    logic        start;
    logic [7:0]  operandA;
    logic [7:0]  operandB;
    logic        signedMode;
    logic [2:0]  destLo;
    logic [2:0]  destHi;
    logic        busy;
    logic        done;
    logic        regWrite;
    logic [2:0]  writeRegister;
    logic [7:0]  writeData;
    logic [15:0] product;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [7:0] regModel [8];

    mult_writeback_unit dut (
        .clock         (clock),
        .resetN        (resetN),
        .start         (start),
        .operandA      (operandA),
        .operandB      (operandB),
        .signedMode    (signedMode),
        .destLo        (destLo),
        .destHi        (destHi),
        .busy          (busy),
        .done          (done),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .product       (product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register-file image built from the observed write port.
    always @(posedge clock) begin
        if (resetN && regWrite) regModel[writeRegister] <= writeData;
    end

    task checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One full operation with the inputs scrambled right after the start edge.
    task runOp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sm,
               input logic [2:0] lo, input logic [2:0] hi, input logic [15:0] expP);
        int writesSeen;
        @(negedge clock);
        operandA = a; operandB = b; signedMode = sm; destLo = lo; destHi = hi; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; operandA = ~a; operandB = 8'h5A; signedMode = ~sm; destLo = ~lo; destHi = ~hi;
        checkVal({tag, "_busy"}, 32'(busy), 32'd1);
        writesSeen = 0;
        repeat (7) begin
            @(posedge clock); #1;
            if (regWrite) writesSeen++;
        end
        checkVal({tag, "_nowrite_mul"}, 32'(writesSeen), 32'd0);
        @(posedge clock); #1;
        checkVal({tag, "_lo_we"},   32'(regWrite),      32'd1);
        checkVal({tag, "_lo_reg"},  32'(writeRegister), 32'(lo));
        checkVal({tag, "_lo_data"}, 32'(writeData),     32'(expP[7:0]));
        @(posedge clock); #1;
        checkVal({tag, "_hi_we"},   32'(regWrite),      32'd1);
        checkVal({tag, "_hi_reg"},  32'(writeRegister), 32'(hi));
        checkVal({tag, "_hi_data"}, 32'(writeData),     32'(expP[15:8]));
        @(posedge clock); #1;
        checkVal({tag, "_done"},    32'(done),     32'd1);
        checkVal({tag, "_idle"},    32'(busy),     32'd0);
        checkVal({tag, "_we_off"},  32'(regWrite), 32'd0);
        checkVal({tag, "_product"}, 32'(product),  32'(expP));
        @(posedge clock); #1;
        checkVal({tag, "_done_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        int writesSeen;
        logic expW;
        resetN = 1'b0; start = 1'b0; operandA = '0; operandB = '0;
        signedMode = 1'b0; destLo = '0; destHi = '0;
        #2;
        checkVal("rst_busy",  32'(busy),          32'd0);
        checkVal("rst_done",  32'(done),          32'd0);
        checkVal("rst_we",    32'(regWrite),      32'd0);
        checkVal("rst_wreg",  32'(writeRegister), 32'd0);
        checkVal("rst_wdata", 32'(writeData),     32'd0);
        checkVal("rst_prod",  32'(product),       32'd0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;

        runOp("u13x11",   8'd13,  8'd11,  1'b0, 3'd1, 3'd2, 16'h008F);
        runOp("u255x255", 8'hFF,  8'hFF,  1'b0, 3'd4, 3'd5, 16'hFE01);
        runOp("s-3x5",    8'hFD,  8'h05,  1'b1, 3'd1, 3'd2, 16'hFFF1);
        runOp("s-128sq",  8'h80,  8'h80,  1'b1, 3'd6, 3'd7, 16'h4000);
        runOp("s127x-1",  8'h7F,  8'hFF,  1'b1, 3'd2, 3'd1, 16'hFF81);
        runOp("s-1x-128", 8'hFF,  8'h80,  1'b1, 3'd3, 3'd4, 16'h0080);
        runOp("u0xFF",    8'h00,  8'hFF,  1'b0, 3'd5, 3'd6, 16'h0000);
        runOp("dest0",    8'd7,   8'd9,   1'b0, 3'd0, 3'd0, 16'h003F);
        runOp("sameDest", 8'h12,  8'h34,  1'b0, 3'd3, 3'd3, 16'h03A8);
        checkVal("sameDest_reg3", 32'(regModel[3]), 32'h03);

        // Start pulse while busy is ignored; start held across the last write edge chains.
        @(negedge clock);
        operandA = 8'd6; operandB = 8'd7; signedMode = 1'b0; destLo = 3'd4; destHi = 3'd5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            expW = (c == 8) || (c == 9) || (c == 18) || (c == 19);
            checkVal($sformatf("b2b_we_%0d", c), 32'(regWrite), 32'(expW));
            checkVal($sformatf("b2b_done_%0d", c), 32'(done), 32'((c == 10) || (c == 20)));
            if (c == 8)  checkVal("b2b_w1", 32'({writeRegister, writeData}), 32'({3'd4, 8'h2A}));
            if (c == 9)  checkVal("b2b_w2", 32'({writeRegister, writeData}), 32'({3'd5, 8'h00}));
            if (c == 18) checkVal("b2b_w3", 32'({writeRegister, writeData}), 32'({3'd6, 8'h00}));
            if (c == 19) checkVal("b2b_w4", 32'({writeRegister, writeData}), 32'({3'd7, 8'h01}));
            if (c == 10) begin
                checkVal("b2b_prod1", 32'(product), 32'h002A);
                checkVal("b2b_busy10", 32'(busy), 32'd1);
            end
            if (c == 2) begin
                start = 1'b1; operandA = 8'd99; operandB = 8'd99; destLo = 3'd1; destHi = 3'd1;
            end
            if (c == 3) start = 1'b0;
            if (c == 9) begin
                start = 1'b1; operandA = 8'h10; operandB = 8'h10; signedMode = 1'b0;
                destLo = 3'd6; destHi = 3'd7;
            end
            if (c == 11) begin
                start = 1'b0; operandA = 8'hAA; operandB = 8'h55; destLo = 3'd2; destHi = 3'd2;
            end
        end
        checkVal("b2b_prod2", 32'(product), 32'h0100);

        // Reset in the middle of an operation aborts it immediately.
        @(negedge clock);
        operandA = 8'd200; operandB = 8'd3; signedMode = 1'b0; destLo = 3'd1; destHi = 3'd2; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        resetN = 1'b0;
        #1;
        checkVal("arst_busy", 32'(busy),     32'd0);
        checkVal("arst_we",   32'(regWrite), 32'd0);
        checkVal("arst_prod", 32'(product),  32'd0);
        checkVal("arst_done", 32'(done),     32'd0);
        @(negedge clock);
        resetN = 1'b1;
        writesSeen = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (regWrite) writesSeen++;
        end
        checkVal("arst_nowrite", 32'(writesSeen), 32'd0);
        checkVal("arst_idle",    32'(busy),       32'd0);

        runOp("postRst", 8'd3, 8'd4, 1'b0, 3'd2, 3'd3, 16'h000C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
